// File: rtl/multicycle_control.sv
// Main controller for the multicycle RV32I core: a Moore FSM that steps each
// instruction through fetch/decode/execute/memory/writeback and drives the datapath.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t     state_q, state_d;
  state_t     out_state;
  logic [2:0] alu_func;
  logic       op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:                  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:                 state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:   state_d = S_ALUWB;
      default:                   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // funct7b5 only selects sub for R-type (op[5]=1); addi never subtracts.
  always_comb begin
    alu_func = ALU_ADD;
    case (funct3)
      3'b000:  alu_func = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_func = ALU_SLT;
      3'b110:  alu_func = ALU_OR;
      3'b111:  alu_func = ALU_AND;
      default: alu_func = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // While reset is high the selects show FETCH values whatever the state register holds.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_func;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_func;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control words are built
// from the state/output tables and compared cycle by cycle against the DUT.
module tb_multicycle_control;

  localparam int W = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int checks = 0;
  int fails  = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  wire [W-1:0] out_vec = {pc_write, adr_src, mem_write, ir_write, reg_write,
                          result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] m_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (f7 && o[5]) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [W-1:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic ill,
                                       input logic [6:0] o);
    return {pcw, adr, mw, irw, rw, rs, a, b, m_imm(o), alu, ill};
  endfunction

  function automatic logic [W-1:0] fetch_vec(input logic [6:0] o);
    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, o);
  endfunction

  function automatic logic [W-1:0] reset_vec(input logic [6:0] o);
    return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, o);
  endfunction

  // Push the whole cycle-by-cycle control sequence one instruction should produce.
  task automatic model_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    logic legal;
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    exp_q.push_back(fetch_vec(o));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, !legal, o));
    case (o)
      7'b0000011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, o));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, o));
      end
      7'b0100011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, o));
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
      end
      7'b0110011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, m_alu(o, f3, f7), 0, o));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
      end
      7'b0010011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, m_alu(o, f3, f7), 0, o));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
      end
      7'b1100011:
        exp_q.push_back(mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, o));
      7'b1101111: begin
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, o));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Entered in a FETCH cycle just after the falling edge; leaves in the next FETCH cycle.
  task automatic drive_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int n0;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    n0 = exp_q.size();
    model_instr(o, f3, f7, z);
    #1;
    for (int i = n0; i < exp_q.size(); i++) begin
      act_q.push_back(out_vec);
      @(negedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_vec !== reset_vec(op)) begin
      fails++; $display("FAIL reset_hold: got %h expected %h", out_vec, reset_vec(op));
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (out_vec !== fetch_vec(op)) begin
      fails++; $display("FAIL reset_release_fetch: got %h expected %h", out_vec, fetch_vec(op));
    end
  endtask

  task automatic test_lw();
    drive_instr(7'b0000011, 3'd2, 1'b0, 1'b1);
    drive_instr(7'b0110011, 3'd7, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin fails++; $display("FAIL lw step %0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_rtype_sub();
    drive_instr(7'b0110011, 3'd0, 1'b1, 1'b0);
    drive_instr(7'b0110011, 3'd6, 1'b1, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin fails++; $display("FAIL rtype step %0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_addi();
    drive_instr(7'b0010011, 3'd0, 1'b1, 1'b0);
    drive_instr(7'b0010011, 3'd2, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin fails++; $display("FAIL addi step %0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_beq();
    drive_instr(7'b1100011, 3'd0, 1'b0, 1'b1);
    drive_instr(7'b1100011, 3'd0, 1'b0, 1'b0);
    drive_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin fails++; $display("FAIL beq step %0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_jal();
    drive_instr(7'b1101111, 3'd5, 1'b1, 1'b0);
    drive_instr(7'b0100011, 3'd2, 1'b0, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin fails++; $display("FAIL jal step %0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_illegal();
    drive_instr(7'b1111111, 3'd0, 1'b0, 1'b1);
    drive_instr(7'b0000000, 3'd3, 1'b1, 1'b0);
    drive_instr(7'b0010011, 3'd7, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin fails++; $display("FAIL illegal step %0d: got %h expected %h", i, a, e); end
    end
  endtask

  task automatic test_reset_mid_store();
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if (mem_write !== 1'b1) begin
      fails++; $display("FAIL store_memwrite_before_reset: got %b expected 1", mem_write);
    end
    reset = 1'b1; #1;
    checks++;
    if (out_vec !== reset_vec(op)) begin
      fails++; $display("FAIL reset_in_memwrite: got %h expected %h", out_vec, reset_vec(op));
    end
    @(negedge clk); #1;
    checks++;
    if (out_vec !== reset_vec(op)) begin
      fails++; $display("FAIL reset_second_cycle: got %h expected %h", out_vec, reset_vec(op));
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (out_vec !== fetch_vec(op)) begin
      fails++; $display("FAIL fetch_after_reset: got %h expected %h", out_vec, fetch_vec(op));
    end
  endtask

  task automatic test_back_to_back_random();
    logic [6:0] ops[7];
    logic [6:0] o;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
    for (int k = 0; k < 300; k++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 7'b0000000) o = 7'($urandom_range(0, 127));
      drive_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin fails++; $display("FAIL random step %0d: got %h expected %h", i, a, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lw();
    test_rtype_sub();
    test_addi();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_store();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main controller for the multicycle RV32I core. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. It drives every enable and mux select in the datapath, including `imm_src` for the immediate extender and `alu_control` for the ALU. It supports lw, sw, R-type ALU, I-type ALU, beq and jal, and flags any other opcode as illegal.

## Interface
Parameters: none.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: instr[6:0], the opcode.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag, valid in the BEQ state.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction and OldPC register enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result select; 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1 data.
- `alu_src_b` out 2: ALU B select; 00 = rs2 data, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: ALU operation; 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `illegal` out 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH → DECODE.
  - From DECODE by `op`:
    - 0000011 / 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - any other opcode → FETCH, with `illegal` = 1.
  - MEMADR → MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR / EXECI / JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Per-state outputs. Unlisted signals are 0; unlisted selects are 00.
  - FETCH: `adr_src` 0, `ir_write` 1, A = PC, B = 4, ALU add, `result_src` 10, `pc_write` 1.
  - DECODE: A = OldPC, B = imm, add (computes the branch/jump target).
  - MEMADR: A = rs1, B = imm, add.
  - MEMREAD: `result_src` 00, `adr_src` 1.
  - MEMWB: `result_src` 01, `reg_write` 1.
  - MEMWRITE: `result_src` 00, `adr_src` 1, `mem_write` 1.
  - EXECR: A = rs1, B = rs2, function decode.
  - EXECI: A = rs1, B = imm, function decode.
  - ALUWB: `result_src` 00, `reg_write` 1.
  - BEQ: A = rs1, B = rs2, sub, `result_src` 00, `pc_write` = `zero`.
  - JAL: A = OldPC, B = 4, add, `result_src` 00, `pc_write` 1.
- Function decode (EXECR/EXECI), by `funct3`:
  - 000: sub when `funct7b5` & `op[5]`, otherwise add. addi never subtracts.
  - 010 → slt; 110 → or; 111 → and.
  - any other `funct3` → add.
- `imm_src` is a combinational function of `op` in every state:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - all others → 00.
- While `reset` = 1:
  - `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0.
  - State loads FETCH at the edge.

## Timing
- All outputs are combinational from the state register (plus `op`, `funct3`, `funct7b5`, `zero`); they are valid in the same cycle.
- First cycle after `reset` deasserts is FETCH. Reset value of state is FETCH. Output values in reset are as listed above; the remaining outputs take their FETCH values.
- Cycle counts including FETCH:
  - lw: 5.
  - sw, R-type, I-type, jal: 4.
  - beq: 3.
  - illegal opcode: 2.
- `zero` is sampled combinationally only in BEQ; it is ignored elsewhere.
- Reset asserted in any state aborts the instruction: no write enable in that cycle, FETCH next.
- No stalls and no handshakes; memory is assumed single-cycle.

## Test plan
- Reset held 2 cycles mid-MEMWRITE → `mem_write` = 0 during reset; FETCH outputs (`ir_write` = 1, `pc_write` = 1, `alu_src_b` = 10) in the first cycle after release.
- lw (`op` = 0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - MEMREAD: `adr_src` = 1.
  - MEMWB: `result_src` = 01, `reg_write` = 1.
  - Next cycle is FETCH.
- R-type sub (`op` = 0110011, `funct3` = 000, `funct7b5` = 1) → `alu_control` = 001 in EXECR, `reg_write` = 1 in ALUWB.
- addi with `funct7b5` = 1 → `alu_control` = 000 in EXECI.
- beq:
  - `zero` = 1 in BEQ → `pc_write` = 1, `alu_control` = 001, `imm_src` = 10.
  - `zero` = 0 → `pc_write` = 0.
  - Either way FETCH follows.
- jal (`op` = 1101111) → `imm_src` = 11.
  - JAL: `pc_write` = 1, `alu_src_a` = 01, `alu_src_b` = 10.
  - ALUWB: `reg_write` = 1.
- Opcode 1111111 → `illegal` = 1 for exactly the DECODE cycle, then FETCH; no write enable asserted.
